// File: rtl/iter_multdiv_if.sv
// Operand/result bundle between the execute stage and iter_multdiv.
// The pipeline drives the master side; the unit drives the slave side.
interface iter_multdiv_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    output ctrl_DIV,
    input  data_result,
    input  data_exception,
    input  data_resultRDY
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    input  ctrl_DIV,
    output data_result,
    output data_exception,
    output data_resultRDY
  );
endinterface

// File: rtl/iter_multdiv.sv
// Iterative signed multiply/divide: radix-2 restoring divide, shift-add
// multiply; define MULTDIV_BOOTH4_EN for a radix-4 Booth multiply.
module iter_multdiv #(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  iter_multdiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);
`ifdef MULTDIV_BOOTH4_EN
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2);
`else
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH);
`endif

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [W2-1:0]    p_q;
  logic [WIDTH-1:0] mb_q;
  logic             neg_q;
  logic             dz_q;
  logic             ovf_q;
  logic [WIDTH-1:0] res_q;
  logic             exc_q;
  logic             rdy_q;

  logic             start;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign a_neg = bus.data_operandA[WIDTH-1];
  assign b_neg = bus.data_operandB[WIDTH-1];
  assign a_mag = a_neg ? -bus.data_operandA : bus.data_operandA;
  assign b_mag = b_neg ? -bus.data_operandB : bus.data_operandB;
  assign cnt_d = cnt_q + 1'b1;

  // Restoring step: p_q = {remainder, dividend bits still to shift in}
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_p;
  logic [WIDTH-1:0] quo;

  always_comb begin
    div_ge  = p_q[W2-1:WIDTH-1] >= {1'b0, mb_q};
    div_rem = p_q[W2-2:WIDTH-1] - mb_q;
    div_p   = {div_ge ? div_rem : p_q[W2-2:WIDTH-1],
               p_q[WIDTH-2:0], div_ge};
    quo     = neg_q ? -div_p[WIDTH-1:0] : div_p[WIDTH-1:0];
  end

  logic [W2-1:0] prod;

`ifdef MULTDIV_BOOTH4_EN
  logic [W2-1:0]    bacc_q;
  logic [W2-1:0]    bacc_d;
  logic [W2-1:0]    bmc_q;
  logic [W2-1:0]    pp;
  logic [WIDTH-1:0] bmr_q;
  logic             bprev_q;

  always_comb begin
    pp = '0;
    unique case ({bmr_q[1:0], bprev_q})
      3'b001, 3'b010: pp = bmc_q;
      3'b011:         pp = bmc_q << 1;
      3'b100:         pp = -(bmc_q << 1);
      3'b101, 3'b110: pp = -bmc_q;
      default:        pp = '0;
    endcase
    bacc_d = bacc_q + pp;
    prod   = bacc_d;
  end
`else
  logic [WIDTH-1:0] ma_q;
  logic [WIDTH:0]   mul_hi;
  logic [W2-1:0]    mul_p;

  // Shift-add step: p_q = {partial product, multiplier bits left}
  always_comb begin
    mul_hi = {1'b0, p_q[W2-1:WIDTH]} +
             {1'b0, (p_q[0] ? ma_q : '0)};
    mul_p  = {mul_hi, p_q[WIDTH-1:1]};
    prod   = neg_q ? -mul_p : mul_p;
  end
`endif

  logic [WIDTH:0] prod_hi;
  logic           mul_exc;

  assign prod_hi = prod[W2-1:WIDTH-1];
  assign mul_exc = ~((&prod_hi) | ~(|prod_hi));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef MULTDIV_BOOTH4_EN
      bacc_q  <= '0;
      bmc_q   <= '0;
      bmr_q   <= '0;
      bprev_q <= 1'b0;
`else
      ma_q    <= '0;
`endif
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        state_q <= bus.ctrl_MULT ? MUL : DIV;
        cnt_q   <= '0;
        p_q     <= {{WIDTH{1'b0}},
                    bus.ctrl_MULT ? b_mag : a_mag};
        mb_q    <= b_mag;
        neg_q   <= a_neg ^ b_neg;
        dz_q    <= bus.data_operandB == '0;
        ovf_q   <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (bus.data_operandB == '1);
`ifdef MULTDIV_BOOTH4_EN
        bacc_q  <= '0;
        bmc_q   <= {{WIDTH{a_neg}}, bus.data_operandA};
        bmr_q   <= bus.data_operandB;
        bprev_q <= 1'b0;
`else
        ma_q    <= a_mag;
`endif
      end else begin
        unique case (state_q)
          MUL: begin
            cnt_q <= cnt_d;
`ifdef MULTDIV_BOOTH4_EN
            bacc_q  <= bacc_d;
            bmc_q   <= bmc_q << 2;
            bmr_q   <= {{2{bmr_q[WIDTH-1]}}, bmr_q[WIDTH-1:2]};
            bprev_q <= bmr_q[1];
`else
            p_q   <= mul_p;
`endif
            if (cnt_d == MUL_LAST) begin
              state_q <= DONE;
              res_q   <= prod[WIDTH-1:0];
              exc_q   <= mul_exc;
              rdy_q   <= 1'b1;
            end
          end
          DIV: begin
            cnt_q <= cnt_d;
            p_q   <= div_p;
            if (cnt_d == DIV_LAST) begin
              state_q <= DONE;
              res_q   <= dz_q ? '0 : quo;
              exc_q   <= dz_q | ovf_q;
              rdy_q   <= 1'b1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_iter_multdiv.sv
// Directed bench for iter_multdiv: stimulus pushes expected results,
// a monitor pops and compares on every completion pulse.
module tb_iter_multdiv;
  localparam int W = 32;
`ifdef MULTDIV_BOOTH4_EN
  localparam int ML = 16;
`else
  localparam int ML = 32;
`endif
  localparam int DL = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;

  iter_multdiv_if #(.WIDTH(W)) bus ();

  iter_multdiv #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    int           cyc;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   rdy_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) begin
        rdy_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rdy: got RDY at cycle %0d expected none",
                   cyc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("op%0d_result", e.id), bus.data_result, e.res);
          chk($sformatf("op%0d_exception", e.id),
              {31'b0, bus.data_exception}, {31'b0, e.exc});
          chk($sformatf("op%0d_rdy_cycle", e.id), cyc, e.cyc);
        end
      end
    end
  end

  task automatic start(input bit m, input bit d,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ee,
                       input int lat, input int id, input bit push);
    @(negedge clock);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    if (push) sb.push_back('{er, ee, cyc + 1 + lat, id});
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'hDEADBEEF;
    bus.data_operandB = 32'h0BADF00D;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0",
               sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    chk("reset_result", bus.data_result, 32'h0);
    chk("reset_exception", {31'b0, bus.data_exception}, 32'h0);
    chk("reset_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    start(1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, ML, 1, 1);
    wait_done();
    start(1, 0, 32'h00010000, 32'h00010000, 32'h0, 1, ML, 2, 1);
    wait_done();
    start(1, 0, 32'h40000000, 32'hFFFFFFFE, 32'h80000000, 0, ML, 3, 1);
    wait_done();
    start(0, 1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 0, DL, 4, 1);
    wait_done();
    start(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, DL, 5, 1);
    wait_done();
    start(0, 1, 32'd5, 32'd0, 32'h0, 1, DL, 6, 1);
    wait_done();

    start(1, 0, 32'd2, 32'd3, 32'd6, 0, ML, 7, 1);
    chk("hold_result_on_start", bus.data_result, 32'h0);
    chk("hold_exception_on_start", {31'b0, bus.data_exception}, 32'h1);
    wait_done();

    // Multiply aborted by a divide started ten edges later
    start(1, 0, 32'd3, 32'd4, 32'd12, 0, ML, 0, 0);
    repeat (8) @(negedge clock);
    start(0, 1, 32'd20, 32'd4, 32'd5, 0, DL, 8, 1);
    wait_done();

    start(1, 1, 32'd6, 32'd2, 32'd12, 0, ML, 9, 1);
    wait_done();

    // Divide killed by reset part way through
    start(0, 1, 32'd100, 32'd3, 32'd33, 0, DL, 0, 0);
    repeat (3) @(negedge clock);
    chk("hold_result_during_div", bus.data_result, 32'd12);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_result", bus.data_result, 32'h0);
    chk("async_reset_exception", {31'b0, bus.data_exception}, 32'h0);
    chk("async_reset_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);

    start(1, 0, 32'd9, 32'd9, 32'd81, 0, ML, 11, 1);
    wait_done();

    chk("rdy_pulse_count", rdy_cnt, 32'd10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
